vec_magnitude: RTL and testbench
================================

# vec_magnitude

Computes the Euclidean magnitude sqrt(dx² + dy²) of a signed fixed-point 2-D vector. It squares and sums the components with an iterative shift-add datapath, then acts as the requesting master of the shared `sqrt` unit over its valid/busy handshake. It sits between the physics-object geometry logic (segment lengths, collision normals) and the `sqrt` responder.

## Interface
Parameters:
- INTEGER_BITS, 20, integer bits of the Q format (1 sign + 20 int + 11 frac = 32 bits)
- FRACTIONAL_BITS, 11, fractional bits; products are shifted right by this amount

Ports:
- clk_in  input  1  single system clock
- rst_in  input  1  reset, asynchronous and active-high
- valid_in  input  1  request strobe; accepted only when busy_out=0
- dx_in  input  32  x component, two's complement Q20.11
- dy_in  input  32  y component, two's complement Q20.11
- magnitude_out  output  32  result, non-negative Q20.11; held until next result
- valid_out  output  1  one-cycle pulse, magnitude_out valid
- busy_out  output  1  high from acceptance through the cycle before valid_out
- overflow_out  output  1  sticky per operation; set if any saturation occurred
- sqrt_valid_out  output  1  one-cycle request pulse to the sqrt unit
- sqrt_val_out  output  32  radicand to the sqrt unit
- sqrt_busy_in  input  1  sqrt unit busy
- sqrt_valid_in  input  1  sqrt unit result pulse
- sqrt_result_in  input  32  sqrt unit result

## Operation
- Reset (asynchronous): state IDLE. All outputs 0: magnitude_out, valid_out, busy_out, overflow_out, sqrt_valid_out, sqrt_val_out. Internal registers are cleared.
- States: IDLE, SQ_X, SQ_Y, SUM, REQ, WAIT, DONE.
- IDLE:
  - On valid_in, latch |dx_in| and |dy_in|, clear overflow_out, set busy_out, and go to SQ_X.
  - An input of 0x80000000 takes absolute value 0x7FFFFFFF and sets overflow_out.
- SQ_X / SQ_Y:
  - 32-iteration shift-add squarer, one multiplier bit per cycle, with a 64-bit accumulator.
  - Result = product >> FRACTIONAL_BITS.
  - If the result exceeds 0x7FFFFFFF, saturate it to 0x7FFFFFFF and set overflow_out.
- SUM:
  - sum = x² + y², computed in 33 bits and saturated to 0x7FFFFFFF (sets overflow_out).
  - If sum == 0, set magnitude_out = 0 and go to DONE; no sqrt request is issued.
  - Otherwise load sqrt_val_out = sum and go to REQ.
- REQ:
  - If sqrt_busy_in = 0, pulse sqrt_valid_out for exactly one cycle and go to WAIT.
  - Otherwise wait in REQ.
- WAIT:
  - On sqrt_valid_in, latch magnitude_out = sqrt_result_in and go to DONE.
  - sqrt_val_out stays stable from REQ until this capture.
- DONE: valid_out = 1 and busy_out = 0 for one cycle, then go to IDLE.
- sqrt_valid_in outside WAIT is ignored, e.g. a stale pulse after reset.
- valid_in while busy_out = 1 is ignored, not queued.
- Reset mid-operation aborts immediately and no valid_out is produced. A sqrt operation already in flight completes on its own side; its result is discarded.

## Timing
- Acceptance edge = E0. SQ_X occupies E1..E32, SQ_Y E33..E64, SUM E65.
- With sqrt_busy_in = 0: sqrt_valid_out is high in the cycle after E66 (after exactly one cycle in REQ).
- Each cycle sqrt_busy_in is high while in REQ adds one cycle of delay.
- valid_out is high in the cycle after the edge that samples sqrt_valid_in. Minimum total latency = 68 + sqrt latency.
- Zero-sum path: valid_out is high in the cycle after E66.
- valid_in may be reasserted in the cycle valid_out is high (busy_out = 0 then) and is accepted at that edge.

## Test plan
- (3.0, 4.0): dx = 0x00001800, dy = 0x00002000; behavioural sqrt model returns 0x00002800.
  - Required: sqrt_val_out = 0x0000C800 at request; magnitude_out = 0x00002800; overflow_out = 0.
- (−3.0, −4.0): dx = 0xFFFFE800, dy = 0xFFFFE000.
  - Required: identical sqrt_val_out and magnitude_out to the previous case.
- (0, 0): no sqrt_valid_out ever; valid_out in the cycle after E66; magnitude_out = 0.
- dx = 0x7FFFFFFF, dy = 0:
  - Required: sqrt_val_out = 0x7FFFFFFF and overflow_out = 1 together with valid_out.
  - dx = 0x80000000 likewise sets overflow_out.
- Hold sqrt_busy_in = 1 for 10 cycles upon reaching REQ:
  - Required: sqrt_valid_out delayed exactly 10 cycles, then a single one-cycle pulse.
  - Also required: valid_in pulses during busy are ignored.
- Assert rst_in asynchronously in WAIT, then pulse sqrt_valid_in after release.
  - Required: all outputs 0 immediately, no valid_out, and the next request completes normally.

Source files
------------

// File: rtl/vec_magnitude.sv
// -----------------------------------------------------------------------------
// vec_magnitude
//
// Computes sqrt(dx^2 + dy^2) for a signed Q20.11 2-D vector. Each component is
// squared with a one-bit-per-cycle shift-add multiplier. The two squares are
// summed with saturation. The radicand is then handed to a shared sqrt unit,
// with this block acting as the requesting master over a valid/busy handshake.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   valid_in        request strobe, accepted only while busy_out = 0
//   dx_in, dy_in    vector components, two's complement Q20.11
//   magnitude_out   non-negative Q20.11 result, held until the next result
//   valid_out       one-cycle pulse qualifying magnitude_out
//   busy_out        high from acceptance until the cycle valid_out rises
//   overflow_out    sticky per operation: some stage saturated
//   sqrt_valid_out  one-cycle request pulse to the sqrt unit
//   sqrt_val_out    radicand for the sqrt unit, stable until its result lands
//   sqrt_busy_in    sqrt unit cannot take a request this cycle
//   sqrt_valid_in   sqrt unit result strobe
//   sqrt_result_in  sqrt unit result
// -----------------------------------------------------------------------------
module vec_magnitude #(
    parameter int INTEGER_BITS    = 20,
    parameter int FRACTIONAL_BITS = 11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [31:0] dx_in,
    input  logic [31:0] dy_in,
    output logic [31:0] magnitude_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        overflow_out,
    output logic        sqrt_valid_out,
    output logic [31:0] sqrt_val_out,
    input  logic        sqrt_busy_in,
    input  logic        sqrt_valid_in,
    input  logic [31:0] sqrt_result_in
);

    localparam int          WORD_BITS = 1 + INTEGER_BITS + FRACTIONAL_BITS;
    localparam logic [4:0]  LAST_ITER = 5'(WORD_BITS - 1);
    localparam logic [31:0] MAX_POS   = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_NEG   = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ_X = 3'd1,
        SQ_Y = 3'd2,
        SUM  = 3'd3,
        REQ  = 3'd4,
        WAIT = 3'd5,
        DONE = 3'd6
    } state_t;

    // Returns {saturated, |value|}. The most negative code has no positive
    // twin, so it clips to the largest positive value.
    function automatic logic [32:0] abs_sat(input logic [31:0] value);
        logic [32:0] res;
        if (value == MIN_NEG) begin
            res = {1'b1, MAX_POS};
        end else if (value[31]) begin
            res = {1'b0, 32'h0000_0000 - value};
        end else begin
            res = {1'b0, value};
        end
        return res;
    endfunction

    // Rescales a raw 64-bit product back to Q20.11 and clips to 31 bits.
    // Returns {saturated, result}.
    function automatic logic [32:0] sat_square(input logic [63:0] product);
        logic [63:0] scaled;
        logic [32:0] res;
        scaled = product >> FRACTIONAL_BITS;
        if (scaled > {32'h0000_0000, MAX_POS}) begin
            res = {1'b1, MAX_POS};
        end else begin
            res = {1'b0, scaled[31:0]};
        end
        return res;
    endfunction

    // 33-bit sum of two non-negative squares, clipped to 31 bits.
    // Returns {saturated, sum}.
    function automatic logic [32:0] sat_sum(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] total;
        logic [32:0] res;
        total = {1'b0, a} + {1'b0, b};
        if (total > {1'b0, MAX_POS}) begin
            res = {1'b1, MAX_POS};
        end else begin
            res = {1'b0, total[31:0]};
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      next_state_s;

    logic [63:0] acc_r;        // partial product
    logic [63:0] mcand_r;      // multiplicand, shifted left each step
    logic [31:0] mplier_r;     // multiplier, shifted right each step
    logic [4:0]  iter_r;       // bit position being consumed
    logic [31:0] ay_r;         // |dy|, parked while x is squared
    logic [31:0] x2_r;
    logic [31:0] y2_r;
    logic        sum_zero_r;

    logic [32:0] dx_abs_s;
    logic [32:0] dy_abs_s;
    logic [63:0] acc_next_s;
    logic [32:0] square_s;
    logic [32:0] sum_s;
    logic        last_iter_s;

    // Shared datapath terms for acceptance, squaring and summation.
    always_comb begin
        dx_abs_s    = abs_sat(dx_in);
        dy_abs_s    = abs_sat(dy_in);
        acc_next_s  = acc_r + (mplier_r[0] ? mcand_r : 64'd0);
        square_s    = sat_square(acc_next_s);
        sum_s       = sat_sum(x2_r, y2_r);
        last_iter_s = (iter_r == LAST_ITER);
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. DONE can accept a new request directly because
    // busy_out is already low during that cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_in) next_state_s = SQ_X;
                else          next_state_s = IDLE;
            end
            SQ_X: begin
                if (last_iter_s) next_state_s = SQ_Y;
                else             next_state_s = SQ_X;
            end
            SQ_Y: begin
                if (last_iter_s) next_state_s = SUM;
                else             next_state_s = SQ_Y;
            end
            SUM: begin
                next_state_s = REQ;
            end
            REQ: begin
                // A zero radicand uses its REQ slot silently, so valid_out on
                // the zero path lands one cycle after the request slot.
                if (sum_zero_r)        next_state_s = DONE;
                else if (!sqrt_busy_in) next_state_s = WAIT;
                else                   next_state_s = REQ;
            end
            WAIT: begin
                if (sqrt_valid_in) next_state_s = DONE;
                else               next_state_s = WAIT;
            end
            DONE: begin
                if (valid_in) next_state_s = SQ_X;
                else          next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_r          <= 64'd0;
            mcand_r        <= 64'd0;
            mplier_r       <= 32'd0;
            iter_r         <= 5'd0;
            ay_r           <= 32'd0;
            x2_r           <= 32'd0;
            y2_r           <= 32'd0;
            sum_zero_r     <= 1'b0;
            magnitude_out  <= 32'd0;
            valid_out      <= 1'b0;
            busy_out       <= 1'b0;
            overflow_out   <= 1'b0;
            sqrt_valid_out <= 1'b0;
            sqrt_val_out   <= 32'd0;
        end else begin
            valid_out      <= 1'b0;
            sqrt_valid_out <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (valid_in) begin
                        acc_r        <= 64'd0;
                        mcand_r      <= {32'd0, dx_abs_s[31:0]};
                        mplier_r     <= dx_abs_s[31:0];
                        iter_r       <= 5'd0;
                        ay_r         <= dy_abs_s[31:0];
                        busy_out     <= 1'b1;
                        overflow_out <= dx_abs_s[32] | dy_abs_s[32];
                    end
                end
                SQ_X, SQ_Y: begin
                    if (last_iter_s) begin
                        // Reload the multiplier for y; harmless after SQ_Y.
                        acc_r        <= 64'd0;
                        mcand_r      <= {32'd0, ay_r};
                        mplier_r     <= ay_r;
                        iter_r       <= 5'd0;
                        overflow_out <= overflow_out | square_s[32];
                        if (state_r == SQ_X) x2_r <= square_s[31:0];
                        else                 y2_r <= square_s[31:0];
                    end else begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        iter_r   <= iter_r + 5'd1;
                    end
                end
                SUM: begin
                    sum_zero_r   <= (sum_s[31:0] == 32'd0);
                    overflow_out <= overflow_out | sum_s[32];
                    if (sum_s[31:0] == 32'd0) begin
                        magnitude_out <= 32'd0;
                    end else begin
                        sqrt_val_out <= sum_s[31:0];
                    end
                end
                REQ: begin
                    if (sum_zero_r) begin
                        valid_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end else if (!sqrt_busy_in) begin
                        sqrt_valid_out <= 1'b1;
                    end
                end
                WAIT: begin
                    if (sqrt_valid_in) begin
                        magnitude_out <= sqrt_result_in;
                        valid_out     <= 1'b1;
                        busy_out      <= 1'b0;
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_magnitude.sv
// -----------------------------------------------------------------------------
// Testbench for vec_magnitude. Directed table vectors and randomized vectors are
// checked against an arithmetic reference model. A behavioural sqrt responder
// answers requests after a chosen latency, with optional busy back-pressure.
// -----------------------------------------------------------------------------
module tb_vec_magnitude;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [31:0] dx_in;
    logic [31:0] dy_in;
    logic [31:0] magnitude_out;
    logic        valid_out;
    logic        busy_out;
    logic        overflow_out;
    logic        sqrt_valid_out;
    logic [31:0] sqrt_val_out;
    logic        sqrt_busy_in;
    logic        sqrt_valid_in;
    logic [31:0] sqrt_result_in;

    int checks = 0;
    int errors = 0;

    vec_magnitude dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .dx_in          (dx_in),
        .dy_in          (dy_in),
        .magnitude_out  (magnitude_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out),
        .overflow_out   (overflow_out),
        .sqrt_valid_out (sqrt_valid_out),
        .sqrt_val_out   (sqrt_val_out),
        .sqrt_busy_in   (sqrt_busy_in),
        .sqrt_valid_in  (sqrt_valid_in),
        .sqrt_result_in (sqrt_result_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] dx;
        logic [31:0] dy;
        int          busy;
        int          lat;
        bit          noise;
        logic [31:0] exp_val;
        logic [31:0] exp_mag;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // floor(sqrt(v)) by bitwise search.
    function automatic logic [31:0] isqrt(input longint unsigned v);
        longint unsigned r;
        longint unsigned t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[31:0];
    endfunction

    // Sqrt of a Q20.11 value, in Q20.11.
    function automatic logic [31:0] q_sqrt(input logic [31:0] v);
        return isqrt({21'd0, v, 11'd0});
    endfunction

    function automatic longint unsigned ref_abs(input logic [31:0] v, inout logic ovf);
        if (v == 32'h8000_0000) begin
            ovf = 1'b1;
            return 64'h7FFF_FFFF;
        end else if (v[31]) begin
            return 64'h1_0000_0000 - {32'd0, v};
        end
        return {32'd0, v};
    endfunction

    // Reference model: radicand, overflow flag and zero flag.
    function automatic void ref_model(input logic [31:0] dx, input logic [31:0] dy,
                                      output logic [31:0] val, output logic ovf,
                                      output logic zero);
        longint unsigned ax, ay, sx, sy, s;
        ovf = 1'b0;
        ax = ref_abs(dx, ovf);
        ay = ref_abs(dy, ovf);
        sx = (ax * ax) >> 11;
        sy = (ay * ay) >> 11;
        if (sx > 64'h7FFF_FFFF) begin sx = 64'h7FFF_FFFF; ovf = 1'b1; end
        if (sy > 64'h7FFF_FFFF) begin sy = 64'h7FFF_FFFF; ovf = 1'b1; end
        s = sx + sy;
        if (s > 64'h7FFF_FFFF) begin s = 64'h7FFF_FFFF; ovf = 1'b1; end
        val  = s[31:0];
        zero = (s == 0);
    endfunction

    // Runs one operation from the current negedge. c counts edges after the
    // acceptance edge, sampled at the following negedge. When chain is set,
    // the next request is driven in the valid_out cycle.
    task automatic run_op(input logic [31:0] dx, input logic [31:0] dy,
                          input int busy_cyc, input int lat, input bit noise,
                          input bit predriven, input bit chain,
                          input logic [31:0] ndx, input logic [31:0] ndy,
                          input logic [31:0] exp_val, input logic [31:0] exp_mag,
                          input logic exp_ovf, input logic exp_zero);
        int          req_cnt;
        int          pulse_c;
        int          resp_c;
        logic [31:0] seen_val;
        bit          done;
        bit          unstable;
        if (!predriven) begin
            valid_in = 1'b1;
            dx_in    = dx;
            dy_in    = dy;
        end
        req_cnt = 0; pulse_c = -1; resp_c = -1; seen_val = 32'd0;
        done = 1'b0; unstable = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk_in);
            valid_in = noise && (c == 5 || c == 70);
            if (noise) begin
                dx_in = 32'h0010_0000;
                dy_in = 32'h0010_0000;
            end
            if (c == 0) chk("busy_after_accept", {31'd0, busy_out}, 32'd1);
            sqrt_busy_in = (c >= 65) && (c < 65 + busy_cyc);
            if (sqrt_valid_out) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    pulse_c  = c;
                    seen_val = sqrt_val_out;
                    resp_c   = c + lat;
                end
            end
            if (pulse_c >= 0 && sqrt_val_out !== seen_val) unstable = 1'b1;
            sqrt_valid_in  = (c == resp_c);
            sqrt_result_in = (c == resp_c) ? q_sqrt(seen_val) : 32'hDEAD_BEEF;
            if (valid_out) begin
                done = 1'b1;
                chk("valid_cycle", c, exp_zero ? 32'd66 : 32'(66 + busy_cyc + lat + 1));
                chk("magnitude", magnitude_out, exp_mag);
                chk("overflow", {31'd0, overflow_out}, {31'd0, exp_ovf});
                chk("busy_at_valid", {31'd0, busy_out}, 32'd0);
                chk("request_count", req_cnt, exp_zero ? 32'd0 : 32'd1);
                if (!exp_zero) begin
                    chk("request_cycle", pulse_c, 32'(66 + busy_cyc));
                    chk("radicand", seen_val, exp_val);
                    chk("radicand_stable", {31'd0, unstable}, 32'd0);
                end
            end
        end
        sqrt_valid_in = 1'b0;
        sqrt_busy_in  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no valid_out within 400 cycles for dx=%h dy=%h", dx, dy);
        end
        if (chain) begin
            valid_in = 1'b1;
            dx_in    = ndx;
            dy_in    = ndy;
        end else begin
            valid_in = 1'b0;
            @(negedge clk_in);
            chk("valid_single_cycle", {31'd0, valid_out}, 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_magnitude"}, magnitude_out, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow_out}, 32'd0);
        chk({tag, "_sqrt_valid"}, {31'd0, sqrt_valid_out}, 32'd0);
        chk({tag, "_sqrt_val"}, sqrt_val_out, 32'd0);
    endtask

    initial begin
        logic [31:0] rdx, rdy, rval;
        logic        rovf, rzero;
        bit          saw_valid;

        tbl[0] = '{32'h0000_1800, 32'h0000_2000, 0, 1, 1'b0, 32'h0000_C800, 32'h0000_2800, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_E800, 32'hFFFF_E000, 0, 2, 1'b0, 32'h0000_C800, 32'h0000_2800, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 0, 1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 0, 1, 1'b0, 32'h7FFF_FFFF, 32'h001F_FFFF, 1'b1, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h7FFF_FFFF, 32'h001F_FFFF, 1'b1, 1'b0};
        tbl[5] = '{32'h0000_1800, 32'h0000_2000, 10, 1, 1'b1, 32'h0000_C800, 32'h0000_2800, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_002D, 32'hFFFF_FFD3, 0, 1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[7] = '{32'h0000_0800, 32'h0000_0800, 3, 0, 1'b0, 32'h0000_1000, 32'h0000_0B50, 1'b0, 1'b0};

        rst_in = 1'b1; valid_in = 1'b0; dx_in = 32'd0; dy_in = 32'd0;
        sqrt_busy_in = 1'b0; sqrt_valid_in = 1'b0; sqrt_result_in = 32'd0;
        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].dx, tbl[i].dy, tbl[i].busy, tbl[i].lat, tbl[i].noise,
                   1'b0, 1'b0, 32'd0, 32'd0,
                   tbl[i].exp_val, tbl[i].exp_mag, tbl[i].exp_ovf, tbl[i].exp_zero);
        end

        // Back-to-back: the next request is raised in the valid_out cycle.
        run_op(32'h0000_1800, 32'h0000_2000, 0, 1, 1'b0, 1'b0, 1'b1,
               32'hFFFF_E800, 32'hFFFF_E000, 32'h0000_C800, 32'h0000_2800, 1'b0, 1'b0);
        run_op(32'hFFFF_E800, 32'hFFFF_E000, 0, 1, 1'b0, 1'b1, 1'b0,
               32'd0, 32'd0, 32'h0000_C800, 32'h0000_2800, 1'b0, 1'b0);

        // Asynchronous reset while waiting on the sqrt unit, then a stale result.
        valid_in = 1'b1; dx_in = 32'h0000_1800; dy_in = 32'h0000_2000;
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (67) @(negedge clk_in);
        chk("wait_busy_before_reset", {31'd0, busy_out}, 32'd1);
        #2 rst_in = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        sqrt_valid_in = 1'b1; sqrt_result_in = 32'h0000_1234;
        @(negedge clk_in);
        sqrt_valid_in = 1'b0; sqrt_result_in = 32'd0;
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            if (valid_out || busy_out) saw_valid = 1'b1;
        end
        chk("stale_result_ignored", {31'd0, saw_valid}, 32'd0);
        chk("stale_magnitude", magnitude_out, 32'd0);
        run_op(32'h0000_1800, 32'h0000_2000, 0, 1, 1'b0, 1'b0, 1'b0,
               32'd0, 32'd0, 32'h0000_C800, 32'h0000_2800, 1'b0, 1'b0);

        // Randomized vectors against the reference model.
        for (int i = 0; i < 24; i++) begin
            rdx = 32'($signed($urandom) >>> $urandom_range(8, 31));
            rdy = 32'($signed($urandom) >>> $urandom_range(8, 31));
            if ($urandom_range(0, 9) == 0) rdx = 32'h8000_0000;
            ref_model(rdx, rdy, rval, rovf, rzero);
            run_op(rdx, rdy, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                   1'b0, 1'b0, 32'd0, 32'd0,
                   rval, rzero ? 32'd0 : q_sqrt(rval), rovf, rzero);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
